// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Multi-digit BCD up/down counter with hold, checked synchronous load,
//   programmable top value and wrap-or-saturate behaviour at the bounds.
//
// Parameters
//   DIGITS   number of BCD digits (1..4); count width is 4*DIGITS
//   MAX_VAL  top count as a decimal integer (1 .. 10**DIGITS-1)
//   WRAP     1: wrap at bounds (MAX_VAL->0, 0->MAX_VAL); 0: saturate
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   en        count enable; nothing changes on an edge with en=0
//   ud        mode: 00 hold, 01 down, 10 up, 11 load
//   load_val  BCD load value, digit 0 in bits [3:0]
//   count     registered BCD count
//   tc        one-cycle pulse when a step hits a bound
//   err       one-cycle pulse when a load is rejected
module bcd_updown_counter #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MAX_VAL = 99,
    parameter bit          WRAP    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          ud,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                err
);

    localparam int unsigned W = 4 * DIGITS;

    // Decimal to packed BCD, evaluated at elaboration for MAX_VAL.
    function automatic logic [W-1:0] to_bcd(input int unsigned val);
        logic [W-1:0] r;
        int unsigned  v;
        r = '0;
        v = val;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] val);
        logic [W-1:0] r;
        logic         carry;
        r     = val;
        carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] val);
        logic [W-1:0] r;
        logic         borrow;
        r      = val;
        borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    logic [W-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         err_q, err_d;
    logic         digits_ok;
    logic         load_ok;

    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
    end

    // With all digits valid, plain binary compare of BCD words orders them numerically.
    assign load_ok = digits_ok && (load_val <= MAX_BCD);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        err_d   = 1'b0;
        // ud and load_val are not looked at when en=0.
        if (en) begin
            unique case (ud)
                2'b00: count_d = count_q;
                2'b01: begin
                    if (count_q == '0) begin
                        tc_d = 1'b1;
                        if (WRAP) count_d = MAX_BCD;
                    end else begin
                        count_d = bcd_dec(count_q);
                    end
                end
                2'b10: begin
                    if (count_q == MAX_BCD) begin
                        tc_d = 1'b1;
                        if (WRAP) count_d = '0;
                    end else begin
                        count_d = bcd_inc(count_q);
                    end
                end
                2'b11: begin
                    if (load_ok) begin
                        count_d = load_val;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] ud;
    logic [7:0] load_val;

    // a: MAX_VAL=99 wrap, b: MAX_VAL=59 wrap, s: MAX_VAL=99 saturate
    logic [7:0] count_a, count_b, count_s;
    logic       tc_a, tc_b, tc_s;
    logic       err_a, err_b, err_s;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] HOLD = 2'b00, DOWN = 2'b01, UP = 2'b10, LOAD = 2'b11;

    bcd_updown_counter #(.DIGITS(2), .MAX_VAL(99), .WRAP(1'b1)) u_a (
        .clk(clk), .rst(rst), .en(en), .ud(ud), .load_val(load_val),
        .count(count_a), .tc(tc_a), .err(err_a)
    );

    bcd_updown_counter #(.DIGITS(2), .MAX_VAL(59), .WRAP(1'b1)) u_b (
        .clk(clk), .rst(rst), .en(en), .ud(ud), .load_val(load_val),
        .count(count_b), .tc(tc_b), .err(err_b)
    );

    bcd_updown_counter #(.DIGITS(2), .MAX_VAL(99), .WRAP(1'b0)) u_s (
        .clk(clk), .rst(rst), .en(en), .ud(ud), .load_val(load_val),
        .count(count_s), .tc(tc_s), .err(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic e, input logic [1:0] m, input logic [7:0] v);
        en       = e;
        ud       = m;
        load_val = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        ud       = HOLD;
        load_val = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 32'(count_a), 32'h00);
        check("reset_tc", 32'(tc_a), 32'h0);
        check("reset_err", 32'(err_a), 32'h0);
        rst = 1'b0;

        // 1: asynchronous reset mid-count
        step(1'b1, LOAD, 8'h45);
        check("t1_load", 32'(count_a), 32'h45);
        step(1'b1, UP, 8'h00);
        check("t1_up", 32'(count_a), 32'h46);
        rst = 1'b1;
        #1;
        check("t1_async_count_a", 32'(count_a), 32'h00);
        check("t1_async_count_b", 32'(count_b), 32'h00);
        check("t1_async_tc", 32'(tc_a), 32'h0);
        check("t1_async_err", 32'(err_a), 32'h0);
        #1;
        rst = 1'b0;

        // 2: BCD carry
        step(1'b1, LOAD, 8'h08);
        check("t2_load", 32'(count_a), 32'h08);
        step(1'b1, UP, 8'h00);
        check("t2_up1", 32'(count_a), 32'h09);
        check("t2_up1_tc", 32'(tc_a), 32'h0);
        step(1'b1, UP, 8'h00);
        check("t2_up2", 32'(count_a), 32'h10);
        check("t2_up2_tc", 32'(tc_a), 32'h0);
        step(1'b1, UP, 8'h00);
        check("t2_up3", 32'(count_a), 32'h11);
        check("t2_up3_tc", 32'(tc_a), 32'h0);

        // 3: wrap at MAX_VAL=59
        step(1'b1, LOAD, 8'h58);
        check("t3_load", 32'(count_b), 32'h58);
        step(1'b1, UP, 8'h00);
        check("t3_up1", 32'(count_b), 32'h59);
        check("t3_up1_tc", 32'(tc_b), 32'h0);
        step(1'b1, UP, 8'h00);
        check("t3_up2", 32'(count_b), 32'h00);
        check("t3_up2_tc", 32'(tc_b), 32'h1);
        check("t3_a_no_wrap", 32'(count_a), 32'h60);
        check("t3_a_tc", 32'(tc_a), 32'h0);

        // 4: down wrap 0 -> 59, then borrow-free decrement
        step(1'b1, DOWN, 8'h00);
        check("t4_down1", 32'(count_b), 32'h59);
        check("t4_down1_tc", 32'(tc_b), 32'h1);
        check("t4_a_borrow", 32'(count_a), 32'h59);
        step(1'b1, DOWN, 8'h00);
        check("t4_down2", 32'(count_b), 32'h58);
        check("t4_down2_tc", 32'(tc_b), 32'h0);

        // 5: saturate at 99; load 99 is invalid for b
        step(1'b1, LOAD, 8'h99);
        check("t5_load_s", 32'(count_s), 32'h99);
        check("t5_b_reject", 32'(count_b), 32'h58);
        check("t5_b_err", 32'(err_b), 32'h1);
        check("t5_s_err", 32'(err_s), 32'h0);
        step(1'b1, UP, 8'h00);
        check("t5_up1", 32'(count_s), 32'h99);
        check("t5_up1_tc", 32'(tc_s), 32'h1);
        check("t5_a_wrap", 32'(count_a), 32'h00);
        check("t5_a_wrap_tc", 32'(tc_a), 32'h1);
        check("t5_b_err_clear", 32'(err_b), 32'h0);
        step(1'b1, UP, 8'h00);
        check("t5_up2", 32'(count_s), 32'h99);
        check("t5_up2_tc", 32'(tc_s), 32'h1);
        step(1'b0, UP, 8'h00);
        check("t5_en0_count", 32'(count_s), 32'h99);
        check("t5_en0_tc", 32'(tc_s), 32'h0);
        step(1'b1, HOLD, 8'h00);
        check("t5_hold_count", 32'(count_s), 32'h99);
        check("t5_hold_tc", 32'(tc_s), 32'h0);

        // saturate at 0 going down
        step(1'b1, LOAD, 8'h00);
        check("t5_load0", 32'(count_s), 32'h00);
        step(1'b1, DOWN, 8'h00);
        check("t5_sat0", 32'(count_s), 32'h00);
        check("t5_sat0_tc", 32'(tc_s), 32'h1);

        // 6: rejected loads
        step(1'b1, LOAD, 8'h37);
        check("t6_prep", 32'(count_b), 32'h37);
        step(1'b1, LOAD, 8'h3A);
        check("t6_bad_digit_b", 32'(count_b), 32'h37);
        check("t6_bad_digit_err_b", 32'(err_b), 32'h1);
        check("t6_bad_digit_a", 32'(count_a), 32'h37);
        check("t6_bad_digit_err_a", 32'(err_a), 32'h1);
        check("t6_bad_digit_tc", 32'(tc_a), 32'h0);
        step(1'b1, HOLD, 8'h00);
        check("t6_err_clear", 32'(err_b), 32'h0);
        step(1'b1, LOAD, 8'h60);
        check("t6_over_b", 32'(count_b), 32'h37);
        check("t6_over_err_b", 32'(err_b), 32'h1);
        check("t6_ok_a", 32'(count_a), 32'h60);
        check("t6_ok_err_a", 32'(err_a), 32'h0);
        step(1'b0, LOAD, 8'h3A);
        check("t6_en0_err", 32'(err_b), 32'h0);
        check("t6_en0_count", 32'(count_a), 32'h60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
